// File: rtl/peri_dma_pkg.sv
// peri_dma_pkg: shared types and constants for the peripheral-bus DMA initiator
package peri_dma_pkg;
    localparam int PERI_ADDR_W   = 14;
    localparam int PERI_DATA_W   = 32;
    localparam int DEF_ADDR_STEP = 4;
    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;
endpackage

// File: rtl/peri_dma_if.sv
// peri_dma_if: peripheral bus bundle
//   address, write_data, we, re : driven by the initiator (master)
//   read_data                   : driven by the responder, registered on the re edge
interface peri_dma_if;
    import peri_dma_pkg::*;
    logic [PERI_ADDR_W-1:0] address;
    logic [PERI_DATA_W-1:0] write_data;
    logic [PERI_DATA_W-1:0] read_data;
    logic                   we;
    logic                   re;
    modport master (output address, write_data, we, re, input read_data);
    modport slave  (input address, write_data, we, re, output read_data);
endinterface

// File: rtl/peri_dma_addr_gen.sv
// peri_dma_addr_gen: 14-bit wrapping address register with load and step
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_addr (wins over inc)
//   inc, step  : add step when inc is high
//   addr       : registered address
//   addr_nxt   : value addr takes at the next edge
module peri_dma_addr_gen
    import peri_dma_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   inc,
    input  logic [PERI_ADDR_W-1:0] load_addr,
    input  logic [PERI_ADDR_W-1:0] step,
    output logic [PERI_ADDR_W-1:0] addr,
    output logic [PERI_ADDR_W-1:0] addr_nxt
);
    assign addr_nxt = load ? load_addr : inc ? addr + step : addr;
    always_ff @(posedge clk)
        addr <= !rst_n ? '0 : addr_nxt;
endmodule

// File: rtl/peri_dma.sv
// peri_dma: peripheral-bus DMA, copies length words from src to dst (3 cycles/word)
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : transfer request, accepted only when idle
//   src_addr, dst_addr  : bus addresses, latched on accepted start
//   length              : word count, latched on accepted start
//   src_inc, dst_inc    : advance the address by ADDR_STEP per word
//   busy, done          : transfer in progress, one-cycle completion pulse
//   words_done          : words written in the current or last transfer
//   irq, irq_clr        : sticky completion flag and its clear (PERI_DMA_IRQ_EN only)
//   bus                 : peripheral bus master
module peri_dma
    import peri_dma_pkg::*;
#(
    parameter int ADDR_STEP = DEF_ADDR_STEP,
    parameter int LEN_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PERI_ADDR_W-1:0] src_addr,
    input  logic [PERI_ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]       length,
    input  logic                   src_inc,
    input  logic                   dst_inc,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       words_done,
`ifdef PERI_DMA_IRQ_EN
    output logic                   irq,
    input  logic                   irq_clr,
`endif
    peri_dma_if.master             bus
);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       len_q;
    logic                   src_inc_q, dst_inc_q;
    logic                   accept, last;
    logic [PERI_ADDR_W-1:0] src_cur, src_nxt, dst_cur, dst_nxt;
    logic                   re_d, we_d;
    logic [PERI_ADDR_W-1:0] addr_d;
    logic [PERI_DATA_W-1:0] wdata_d;

    // The done pulse trails the DONE state by one cycle, so the IDLE cycle
    // carrying it must also refuse a new start.
    assign accept = state == IDLE && start && !done;
    assign last   = words_done + ONE == len_q;

    peri_dma_addr_gen u_src (
        .clk(clk), .rst_n(rst_n), .load(accept), .inc(state == WRITE && src_inc_q),
        .load_addr(src_addr), .step(PERI_ADDR_W'(ADDR_STEP)),
        .addr(src_cur), .addr_nxt(src_nxt)
    );

    peri_dma_addr_gen u_dst (
        .clk(clk), .rst_n(rst_n), .load(accept), .inc(state == WRITE && dst_inc_q),
        .load_addr(dst_addr), .step(PERI_ADDR_W'(ADDR_STEP)),
        .addr(dst_cur), .addr_nxt(dst_nxt)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !accept ? IDLE : length == '0 ? DONE : READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = WRITE;
            WRITE:   state_nxt = last ? DONE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with
    // the state itself; the address generators' next values supply the
    // freshly loaded or stepped address. bus.write_data doubles as the
    // capture buffer for the word returned during CAPT.
    always_comb begin
        re_d    = state_nxt == READ;
        we_d    = state_nxt == WRITE;
        addr_d  = re_d ? src_nxt : we_d ? dst_nxt : bus.address;
        wdata_d = state == CAPT ? bus.read_data : bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.re         <= 1'b0;
            bus.we         <= 1'b0;
            bus.address    <= '0;
            bus.write_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_done     <= '0;
            len_q          <= '0;
            src_inc_q      <= 1'b0;
            dst_inc_q      <= 1'b0;
        end else begin
            bus.re         <= re_d;
            bus.we         <= we_d;
            bus.address    <= addr_d;
            bus.write_data <= wdata_d;
            busy           <= accept || (busy && state != DONE);
            done           <= state == DONE;
            if (accept) begin
                len_q      <= length;
                src_inc_q  <= src_inc;
                dst_inc_q  <= dst_inc;
                words_done <= '0;
            end else if (state == WRITE) begin
                words_done <= words_done + ONE;
            end
        end
    end

`ifdef PERI_DMA_IRQ_EN
    // Setting covers both the DONE state edge and the done-pulse edge, so a
    // clear arriving alongside the pulse cannot win.
    always_ff @(posedge clk)
        irq <= !rst_n ? 1'b0 : state == DONE || done || (irq && !irq_clr);
`endif
endmodule
